regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the MIPS datapath. It replaces the
//  single-write, two-read file with NUM_RD read ports and two write ports.
//  Write-through bypass lets a register written in a cycle be read in the same
//  cycle. A post-reset clear sweep lets the storage map onto RAM without a
//  parallel reset. It sits between decode (reads) and writeback (writes).
// PARAMETERS
//  DW        32  data width in bits
//  DEPTH     32  number of registers; power of two, >= 2
//  AW        $clog2(DEPTH)  address width; derived, do not override
//  NUM_RD    2   number of read ports, 1..4
//  ZERO_REG  1   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//  clk        in   1            clock; all state updates on the rising edge
//  rst        in   1            synchronous, active-high reset
//  we0        in   1            write enable, port 0
//  waddr0     in   AW           write address, port 0
//  wdata0     in   DW           write data, port 0
//  we1        in   1            write enable, port 1 (higher priority)
//  waddr1     in   AW           write address, port 1
//  wdata1     in   DW           write data, port 1
//  raddr      in   NUM_RD*AW    packed read addresses; port k uses [k*AW +: AW]
//  rdata      out  NUM_RD*DW    packed read data; port k uses [k*DW +: DW]
//  ready      out  1            1 = file is usable (RUN state)
//  wr_collide out  1            registered pulse: both ports wrote the same live address
// BEHAVIOUR
//  FSM states: INIT, RUN.
//   - rst=1: state<=INIT, clr_ptr<=0, ready<=0, wr_collide<=0.
//   - INIT: each cycle writes 0 to entry clr_ptr, then clr_ptr++.
//   - INIT -> RUN on the cycle clr_ptr==DEPTH-1. The sweep takes exactly DEPTH
//     cycles after rst falls; ready rises on the edge ending the sweep.
//   - rst asserted in any state, including mid-sweep, restarts the sweep from 0.
//  During INIT: we0/we1 are ignored, all rdata = 0, wr_collide stays 0.
//  Writes in RUN, on the rising edge of clk:
//   - port p writes when wep=1 and the address is not a suppressed register 0.
//   - waddr0==waddr1 with both enabled: wdata1 is stored; wr_collide=1 next cycle.
//   - wr_collide is 0 when either write is suppressed (ZERO_REG and address 0).
//  Reads in RUN (combinational, zero latency), priority per port k:
//   - ZERO_REG=1 and raddr_k==0 -> 0.
//   - we1 && waddr1==raddr_k -> wdata1 (bypass).
//   - we0 && waddr0==raddr_k -> wdata0 (bypass).
//   - otherwise the stored value.
//  Data is stored unmodified; there is no width conversion and no partial write.
// STRUCTURE
//  Shared package regfile_pkg: localparams ST_INIT/ST_RUN; function clog2
//  (used where $clog2 is unsupported).
//  Sub-module regfile_rdmux (one per read port, generate loop): zero check plus
//  the bypass priority mux above. Storage, sweep FSM and write logic stay in
//  regfile_mp.
// TESTING
//  1 Reset sweep: hold rst for 2 cycles, release -> ready=0 for exactly 32 cycles,
//    then 1; every register reads 0.
//  2 Basic write/bypass: we0=1, waddr0=5, wdata0=500 -> rdata port0 (raddr=5)
//    = 500 in the same cycle; the value holds after we0=0.
//  3 Collision: we0/we1 both to reg 7 with 0x11/0x22 -> reg 7 = 0x22 and
//    wr_collide=1 for one cycle; bypass shows 0x22.
//  4 Zero register: write 0xFFFF to reg 0 on both ports -> reads 0 and
//    wr_collide=0. Repeat with ZERO_REG=0 -> reads 0xFFFF.
//  5 Mid-sweep reset: assert rst 10 cycles into INIT -> sweep restarts and
//    ready rises 32 cycles after release; writes during INIT are not retained.
//  6 NUM_RD=4, DEPTH=16: four ports read distinct registers 1,2,3,15 after
//    writes 1,2,3,15 -> each port returns its own value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The FSM state encoding and an elaboration-time log2 live here.
package regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Ceiling log2 for tools that lack $clog2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_rdmux.sv
// One read port of the register file: register-0 squash plus the
// write-through bypass, with port 1 taking priority over port 0.
module regfile_rdmux
    import regfile_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          run_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          we0_i,
    input  logic [AW-1:0] waddr0_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] waddr1_i,
    input  logic [DW-1:0] wdata1_i,
    input  logic [DW-1:0] stored_i,
    output logic [DW-1:0] rdata_o
);

    always_comb begin
        rdata_o = '0;
        if (!run_i) begin
            rdata_o = '0;
        end else if ((ZERO_REG != 0) && (raddr_i == '0)) begin
            rdata_o = '0;
        end else if (we1_i && (waddr1_i == raddr_i)) begin
            rdata_o = wdata1_i;
        end else if (we0_i && (waddr0_i == raddr_i)) begin
            rdata_o = wdata0_i;
        end else begin
            rdata_o = stored_i;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD bypassed read ports, two write ports,
// and a post-reset clear sweep so storage needs no parallel reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = clog2(DEPTH),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we0,
    input  logic [AW-1:0]        waddr0,
    input  logic [DW-1:0]        wdata0,
    input  logic                 we1,
    input  logic [AW-1:0]        waddr1,
    input  logic [DW-1:0]        wdata1,
    input  logic [NUM_RD*AW-1:0] raddr,
    output logic [NUM_RD*DW-1:0] rdata,
    output logic                 ready,
    output logic                 wr_collide
);

    state_e        state_q;
    logic [AW-1:0] clr_ptr_q;
    logic          ready_q;
    logic          wr_collide_q;
    logic          wr_collide_d;
    logic          wr0_live;
    logic          wr1_live;
    logic          run;
    logic [DW-1:0] mem_q [DEPTH];

    assign run = (state_q == ST_RUN);

    // A write to register 0 is dropped entirely when it is hardwired to zero.
    assign wr0_live     = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_live     = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
    assign wr_collide_d = wr0_live && wr1_live && (waddr0 == waddr1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            clr_ptr_q    <= '0;
            ready_q      <= 1'b0;
            wr_collide_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    clr_ptr_q    <= clr_ptr_q + 1'b1;
                    wr_collide_q <= 1'b0;
                    if (clr_ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    wr_collide_q <= wr_collide_d;
                end
                default: begin
                    state_q <= ST_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the INIT sweep clears one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (!rst) begin
            if (wr0_live && !wr_collide_d) begin
                mem_q[waddr0] <= wdata0;
            end
            if (wr1_live) begin
                mem_q[waddr1] <= wdata1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] stored;

        assign ra     = raddr[k*AW +: AW];
        assign stored = mem_q[ra];

        regfile_rdmux #(
            .DW       (DW),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rdmux (
            .run_i    (run),
            .raddr_i  (ra),
            .we0_i    (we0),
            .waddr0_i (waddr0),
            .wdata0_i (wdata0),
            .we1_i    (we1),
            .waddr1_i (waddr1),
            .wdata1_i (wdata1),
            .stored_i (stored),
            .rdata_o  (rdata[k*DW +: DW])
        );
    end

    assign ready      = ready_q;
    assign wr_collide = wr_collide_q;

endmodule
